// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving one shared full adder
//
// Purpose : adds a + b + cin one bit per clock, LSB first, through a single
//           full_adder cell, with a start/busy/done handshake.
// Ports   : clk, rst_n (async active-low)
//           start, a[WIDTH], b[WIDTH], cin      - request and operands (captured on accept)
//           busy, done                          - in-flight flag, one-cycle completion pulse
//           sum[WIDTH], carry                   - registered result, held until next completion
//           ovf (only with SERIAL_ADD_OVF_EN)   - signed overflow of the last result
// Option  : define SERIAL_ADD_OVF_EN to add the ovf output.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Only the upper WIDTH-1 result bits need storing: the final bit comes
    // straight from the adder on the last edge.
    logic [WIDTH-2:0]   res_sh_q, res_sh_d;
    logic               c_ff_q, c_ff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_sum;
    logic               fa_carry;
    logic               last_bit;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (c_ff_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            c_ff_q   <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            c_ff_q   <= c_ff_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        c_ff_d   = c_ff_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                // DONE accepts a new start directly so back-to-back ops lose no cycle.
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    c_ff_d   = cin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                res_sh_d = (WIDTH-1)'({fa_sum, res_sh_q} >> 1);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                c_ff_d   = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = {fa_sum, res_sh_q};
                    carry_d = fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                    // Carry into the MSB differs from carry out of it.
                    ovf_d   = c_ff_q ^ fa_carry;
`endif
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; overflow when operands share a sign
    // and the result sign differs.
    function automatic int ref_total(input int x, input int y, input int c);
        return x + y + c;
    endfunction

    function automatic bit ref_ovf(input int x, input int y, input int c);
        int s;
        s = (x + y + c) % 256;
        return ((x >= 128) == (y >= 128)) && ((s >= 128) != (x >= 128));
    endfunction

    // Drives one request at a negedge, scrambles operand inputs after the
    // accept edge, and counts negedges until done (bounded). Reports how many
    // sampled cycles had busy high and on which cycle done was seen (0 = never).
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          output int busy_cycles, output int done_cycle);
        busy_cycles = 0;
        done_cycle  = 0;
        start = 1'b1;
        a     = xa;
        b     = xb;
        cin   = xc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h carry=%b, required 0 0 00 0",
                     busy, done, sum, carry);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb [5] = '{8'h33, 8'h01, 8'hFF, 8'h01, 8'h80};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int bc, dc, tot;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], bc, dc);
            tot = ref_total(int'(va[i]), int'(vb[i]), int'(vc[i]));
            checks++;
            if (bc != 8 || dc != 9) begin
                errors++;
                $display("FAIL vec%0d_latency: busy_cycles=%0d done_cycle=%0d, required 8 9", i, bc, dc);
            end
            checks++;
            if (sum !== 8'(tot) || carry !== 1'(tot >> 8)) begin
                errors++;
                $display("FAIL vec%0d_result: sum=%h carry=%b, required %h %b",
                         i, sum, carry, 8'(tot), 1'(tot >> 8));
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ovf !== ref_ovf(int'(va[i]), int'(vb[i]), int'(vc[i]))) begin
                errors++;
                $display("FAIL vec%0d_ovf: ovf=%b, required %b", i, ovf,
                         ref_ovf(int'(va[i]), int'(vb[i]), int'(vc[i])));
            end
`endif
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sum !== 8'(tot)) begin
                errors++;
                $display("FAIL vec%0d_hold: done=%b sum=%h, required 0 %h", i, done, sum, 8'(tot));
            end
        end
    endtask

    task automatic test_random;
        int bc, dc, tot;
        int bad;
        logic [7:0] ra, rb;
        logic       rc;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, bc, dc);
            tot = ref_total(int'(ra), int'(rb), int'(rc));
            checks++;
            if (dc != 9 || sum !== 8'(tot) || carry !== 1'(tot >> 8)) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h cin=%b done_cycle=%0d sum=%h carry=%b, required 9 %h %b",
                         i, ra, rb, rc, dc, sum, carry, 8'(tot), 1'(tot >> 8));
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ovf !== ref_ovf(int'(ra), int'(rb), int'(rc))) begin
                errors++;
                $display("FAIL random%0d_ovf: ovf=%b", i, ovf);
            end
`endif
            if (($urandom & 1) != 0) @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy;
        int pulses;
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) pulses++;
            start = busy;
            a = 8'h01; b = 8'h01; cin = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_start_pulses: done_pulses=%0d, required 1", pulses);
        end
        checks++;
        if (sum !== 8'h30 || carry !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: sum=%h carry=%b, required 30 0", sum, carry);
        end
    endtask

    task automatic test_back_to_back;
        int bc, dc;
        run_op(8'h5A, 8'h33, 1'b0, bc, dc);
        checks++;
        if (dc != 9 || sum !== 8'h8D) begin
            errors++;
            $display("FAIL b2b_first: done_cycle=%0d sum=%h, required 9 8d", dc, sum);
        end
        // Still in the DONE cycle: start here must be accepted immediately.
        run_op(8'h0F, 8'h01, 1'b0, bc, dc);
        checks++;
        if (dc != 9 || bc != 8) begin
            errors++;
            $display("FAIL b2b_spacing: done_cycle=%0d busy_cycles=%0d, required 9 8", dc, bc);
        end
        checks++;
        if (sum !== 8'h10 || carry !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: sum=%h carry=%b, required 10 0", sum, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int pulses, bc, dc;
        run_op(8'hFF, 8'hFF, 1'b1, bc, dc);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sum !== 8'hFF) begin
            errors++;
            $display("FAIL pre_abort: busy=%b sum=%h, required 1 ff", busy, sum);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b sum=%h carry=%b, required 0 0 00 0",
                     busy, done, sum, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: active_cycles=%0d, required 0", pulses);
        end
        run_op(8'hA5, 8'h5B, 1'b1, bc, dc);
        checks++;
        if (dc != 9 || sum !== 8'h01 || carry !== 1'b1) begin
            errors++;
            $display("FAIL after_abort: done_cycle=%0d sum=%h carry=%b, required 9 01 1", dc, sum, carry);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        test_reset;
        test_vectors;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_shift;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder controller. It time-multiplexes a single full_adder cell (ports a, b, cin, sum, carry) over WIDTH clock cycles, one bit per cycle, LSB first. A carry flip-flop holds the carry between bits. A start/busy/done handshake connects it to the surrounding logic, giving a low-area alternative to a ripple-carry adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new addition; sampled only when not busy.
a  input  WIDTH  operand A; captured on the accepted start edge.
b  input  WIDTH  operand B; captured on the accepted start edge.
cin  input  1  carry-in; captured on the accepted start edge.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when sum/carry become valid.
sum  output  WIDTH  registered result, held until the next accepted start completes.
carry  output  1  registered carry-out of the MSB, held with sum.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, carry=0; operand shift registers, carry flop and bit counter cleared. Release is synchronous to clk in practice; no operation is in progress after reset.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On an edge with start=1:
  - load a_sh<=a, b_sh<=b, c_ff<=cin, cnt<=0, res_sh<=0;
  - go to SHIFT.
- SHIFT: busy=1, done=0. Each edge:
  - the full_adder sees a_sh[0], b_sh[0], c_ff;
  - res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1 (zero fill);
  - c_ff<=fa_carry; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge (last bit), also load sum<={fa_sum,res_sh[WIDTH-1:1]}, carry<=fa_carry, and go to DONE.
- DONE: busy=0, done=1 for exactly this one cycle.
  - Next edge: start=1 behaves as IDLE-accept (load, go to SHIFT, back-to-back); otherwise go to IDLE.
- Latency: start accepted at edge E0; SHIFT edges are E1..EWIDTH; done is high in the cycle following EWIDTH. Total is WIDTH+1 cycles from accept to done, and a new accept is possible on the edge ending DONE.
- start while busy=1: ignored, with no effect on the operation in flight.
- a/b/cin changes after the accept edge: no effect, because operands are captured.
- sum/carry update only on the final SHIFT edge. Between operations they hold the last result, including while the next operation is busy.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, with no saturation.
- Reset asserted mid-SHIFT: abort immediately and apply all reset values; the partial result is discarded and no done pulse occurs.
- The counter never exceeds WIDTH-1 in SHIFT, so there is no wrap condition.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined: extra output port ovf (1 bit, reset 0) is present. It is loaded with the signed two's-complement overflow on the final SHIFT edge: carry into MSB XOR carry out of MSB, i.e. c_ff XOR fa_carry at the last bit. ovf is held with sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy for 8 cycles, done pulse in cycle 9, sum=0x8D, carry=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
- Start pulse every cycle while busy (a=0x01,b=0x01) during an op on a=0x10,b=0x20 -> only the first is accepted; sum=0x30, single done pulse.
- start held high in the DONE cycle with a=0x0F, b=0x01 -> new op accepted with no IDLE cycle; second done exactly 9 cycles after the first, sum=0x10.
- rst_n pulsed low at SHIFT cycle 4 -> busy, done, sum, carry all 0 immediately; no done pulse afterwards; a fresh op after release is correct.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, carry=0, ovf=1; a=0xFF, b=0x01 -> carry=1, ovf=0.
